mfe_rank_filter: RTL and testbench
==================================

// Module: mfe_rank_filter
// PURPOSE
//  Parametrised successor of the 3x3 median filter engine. Streams a W x H greyscale image from the
//  image ROM (iaddr/idata), computes a 3x3 rank filter per pixel (median/min/max) with selectable
//  border handling (zero pad or edge replicate), writes results raster-order to result RAM.
//  Column-sliding window: 3 ROM reads per pixel (6 at row start) instead of a full 9-pixel refetch.
// PARAMETERS
//  IMG_W  128  image width in pixels (>=2)
//  IMG_H  128  image height in pixels (>=2)
//  DW     8    pixel width in bits
//  AW     14   address width; must satisfy 2**AW >= IMG_W*IMG_H
// PORTS
//  clk       in   1   clock, all state on rising edge
//  reset_n   in   1   asynchronous active-low reset
//  ready     in   1   frame request; sampled only in IDLE
//  mode      in   2   00 median, 01 min, 10 max, 11 reserved (=median); captured at frame start
//  pad_mode  in   1   0 zero pad, 1 replicate nearest edge pixel; captured at frame start
//  busy      out  1   high from cycle after ready accepted until last write done
//  iaddr     out  AW  ROM read address (registered)
//  idata     in   DW  ROM data; combinational from iaddr, sampled at edge closing the cycle
//  addr      out  AW  result RAM write address = y*IMG_W+x
//  data_wr   out  DW  filtered pixel
//  wen       out  1   write strobe, exactly 1 cycle per pixel
//  done      out  1   1-cycle pulse on the cycle after the final write
// BEHAVIOUR
//  Reset: busy=0, wen=0, done=0, iaddr=0, addr=0, data_wr=0, window regs=0, FSM=IDLE. Reset
//   asserted mid-frame aborts immediately; no partial write completes; new frame needs ready.
//  FSM: IDLE -(ready)-> START(1 cyc: latch mode/pad_mode, x=y=0) -> FETCH -> SORT -> WRITE
//   -> FETCH (next pixel) | DONE (after pixel W*H-1) -> IDLE. DONE drives done=1, busy=0.
//  ready while not IDLE ignored. ready held high in IDLE re-launches next frame after DONE.
//  Window: 3 columns x 3 rows, registers win[r][c]. FETCH at x=0 reads columns 0 and 1 (6 slots,
//   order col0 rows y-1,y,y+1 then col1); at x>0 shifts window left once, reads column x+1 (3 slots).
//  Coordinates clamped to [0,IMG_W-1]x[0,IMG_H-1] before forming iaddr; iaddr never out of range.
//   Slot whose unclamped coordinate is outside image loads 0 if pad_mode=0, else clamped ROM value.
//   Left column at x=0 (col -1): loaded as 0 or as copy of col0 per pad_mode, no ROM slot used.
//  SORT: 1 cycle load of 9 taps into sorter, then 9 odd-even transposition phases (1/cycle,
//   even phase compares pairs (0,1)(2,3)(4,5)(6,7), odd (1,2)(3,4)(5,6)(7,8)); unsigned compare.
//   Result index: median 4, min 0, max 8.
//  WRITE: 1 cycle, wen=1, addr/data_wr valid same cycle; x,y advance (x wraps at IMG_W-1, y++).
//  Per-pixel cycles: interior x>0: 3 FETCH+10 SORT+1 WRITE = 14; x=0: 17. ready->first wen = 18.
//  Frame total = IMG_H*(17+(IMG_W-1)*14) + 1 (START) cycles from START to last wen inclusive.
//  Corners/edges need no special cases: clamping + pad substitution covers all 8 border classes.
// STRUCTURE
//  Shared package mfe_pkg: localparams MODE_MEDIAN/MODE_MIN/MODE_MAX, PAD_ZERO/PAD_REPL,
//   FSM state encoding (IDLE,START,FETCH,SORT,WRITE,DONE), RANK_IDX per mode.
//  Sub-module mfe_sort9 (DW param): 9-entry odd-even transposition sorter, ports load, phase,
//   in[9], out[9]; sequential, one phase per enabled cycle. Top holds FSM, counters, window, addr.
// TESTING
//  T1 IMG_W=IMG_H=4, ramp pixel=addr*10, median, zero pad -> addr0 out 0, addr5 out 50,
//   addr15 out 0 (5 zeros of 9); exactly 16 wen pulses, done once, busy low after.
//  T2 same image, pad_mode=1, mode=max -> addr0 out 50, addr15 out 150; mode=min addr5 out 0.
//  T3 default 128x128 constant 8'hFF, zero pad, median -> interiors FF, corners 00, edges FF;
//   ready->first wen 18 cycles, interior wen spacing 14, row-start spacing 17.
//  T4 reset_n low for 1 cycle mid-row 3 -> busy/wen drop same cycle, addr=0; re-ready restarts
//   at addr0, results bit-exact vs golden model.
//  T5 mode/pad_mode toggled mid-frame, ready pulsed while busy -> no effect on outputs or timing.
//  T6 random 8-bit images, IMG_W=5,IMG_H=3 (non power of two), all 6 mode/pad combos vs C model;
//   assert iaddr < IMG_W*IMG_H every cycle.

Source files
------------

// File: rtl/mfe_pkg.sv
// rtl/mfe_pkg.sv - shared encodings for the 3x3 rank filter engine
package mfe_pkg;

  localparam logic [1:0] MODE_MEDIAN = 2'b00;
  localparam logic [1:0] MODE_MIN    = 2'b01;
  localparam logic [1:0] MODE_MAX    = 2'b10;

  localparam logic PAD_ZERO = 1'b0;
  localparam logic PAD_REPL = 1'b1;

  localparam int RANK_IDX_MEDIAN = 4;
  localparam int RANK_IDX_MIN    = 0;
  localparam int RANK_IDX_MAX    = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    FETCH,
    SORT,
    WRITE,
    DONE
  } state_t;

  // Reserved mode 11 falls through to median.
  function automatic logic [3:0] rank_idx(input logic [1:0] mode);
    case (mode)
      MODE_MIN: return 4'(RANK_IDX_MIN);
      MODE_MAX: return 4'(RANK_IDX_MAX);
      default:  return 4'(RANK_IDX_MEDIAN);
    endcase
  endfunction

endpackage

// File: rtl/mfe_sort9.sv
// rtl/mfe_sort9.sv - 9-entry odd-even transposition sorter, one phase per enabled cycle
module mfe_sort9 #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic          en,
  input  logic          phase,
  input  logic [DW-1:0] in  [9],
  output logic [DW-1:0] out [9]
);

  logic [DW-1:0] v   [9];
  logic [DW-1:0] nxt [9];

  // phase 0 pairs (0,1)(2,3)(4,5)(6,7); phase 1 pairs (1,2)(3,4)(5,6)(7,8)
  always_comb begin
    nxt = v;
    for (int i = 0; i < 8; i++) begin
      if ((((i % 2) == 1) == phase) && (v[i] > v[i+1])) begin
        nxt[i]   = v[i+1];
        nxt[i+1] = v[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 9; i++) v[i] <= '0;
    end else if (load) begin
      v <= in;
    end else if (en) begin
      v <= nxt;
    end
  end

  assign out = v;

endmodule

// File: rtl/mfe_rank_filter.sv
// rtl/mfe_rank_filter.sv - streaming 3x3 median/min/max filter with column-sliding window
module mfe_rank_filter
  import mfe_pkg::*;
#(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int DW    = 8,
  parameter int AW    = 14
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ready,
  input  logic [1:0]    mode,
  input  logic          pad_mode,
  output logic          busy,
  output logic [AW-1:0] iaddr,
  input  logic [DW-1:0] idata,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data_wr,
  output logic          wen,
  output logic          done
);

  localparam logic [AW-1:0] W_A  = AW'(IMG_W);
  localparam logic [AW-1:0] H_A  = AW'(IMG_H);
  localparam logic [AW:0]   W_E  = (AW+1)'(IMG_W);
  localparam logic [AW:0]   H_E1 = (AW+1)'(IMG_H + 1);

  state_t        state, state_nx;
  logic [AW-1:0] x, y, x_nx, y_nx;
  logic [2:0]    slot;
  logic [3:0]    sort_cnt;
  logic [1:0]    mode_q;
  logic          pad_q;
  logic [DW-1:0] win [3][3];
  logic [DW-1:0] taps [9];
  logic [DW-1:0] sorted [9];
  logic          last_slot, last_x, last_pix;
  logic [1:0]    row_sel;
  logic [DW-1:0] pix;

  logic [AW:0]   cur_col, cur_rowp, nl_col, nl_rowp;
  logic          cur_oob;
  logic [AW-1:0] nl_x, nl_y, nl_cc, nl_rc;
  logic [2:0]    nl_s;
  logic          iaddr_ld;

  // Column x+offset of a fetch slot; at x=0 slots 0-2 hit column 0, slots 3-5 column 1.
  function automatic logic [AW:0] col_of(input logic [AW-1:0] px, input logic [2:0] s);
    return {1'b0, px} + {{AW{1'b0}}, (px != '0) || (s >= 3'd3)};
  endfunction

  // Row of a fetch slot biased by +1 so that row -1 is representable as 0.
  function automatic logic [AW:0] rowp_of(input logic [AW-1:0] py, input logic [2:0] s);
    return {1'b0, py} + {{(AW-1){1'b0}}, (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0]};
  endfunction

  assign last_slot = (x == '0) ? (slot == 3'd5) : (slot == 3'd2);
  assign last_x    = (x == W_A - 1'b1);
  assign last_pix  = last_x && (y == H_A - 1'b1);
  assign x_nx      = last_x ? '0 : x + 1'b1;
  assign y_nx      = last_pix ? '0 : (last_x ? y + 1'b1 : y);
  assign row_sel   = (slot >= 3'd3) ? 2'(slot - 3'd3) : slot[1:0];

  assign cur_col  = col_of(x, slot);
  assign cur_rowp = rowp_of(y, slot);
  assign cur_oob  = (cur_col == W_E) || (cur_rowp == '0) || (cur_rowp == H_E1);
  assign pix      = (cur_oob && (pad_q == PAD_ZERO)) ? '0 : idata;

  // iaddr is registered, so it is always computed for the slot of the following cycle.
  assign nl_col  = col_of(nl_x, nl_s);
  assign nl_rowp = rowp_of(nl_y, nl_s);
  assign nl_cc   = (nl_col == W_E) ? W_A - 1'b1 : nl_col[AW-1:0];
  assign nl_rc   = (nl_rowp == '0) ? '0 :
                   (nl_rowp == H_E1) ? H_A - 1'b1 : nl_rowp[AW-1:0] - 1'b1;

  always_comb begin
    state_nx = state;
    iaddr_ld = 1'b0;
    nl_x     = x;
    nl_y     = y;
    nl_s     = slot + 3'd1;
    case (state)
      IDLE:  if (ready) state_nx = START;
      START: begin
        state_nx = FETCH;
        iaddr_ld = 1'b1;
        nl_x     = '0;
        nl_y     = '0;
        nl_s     = '0;
      end
      FETCH: begin
        if (last_slot) state_nx = SORT;
        else           iaddr_ld = 1'b1;
      end
      SORT:  if (sort_cnt == 4'd9) state_nx = WRITE;
      WRITE: begin
        if (last_pix) begin
          state_nx = DONE;
        end else begin
          state_nx = FETCH;
          iaddr_ld = 1'b1;
          nl_x     = x_nx;
          nl_y     = y_nx;
          nl_s     = '0;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      x        <= '0;
      y        <= '0;
      slot     <= '0;
      sort_cnt <= '0;
      mode_q   <= MODE_MEDIAN;
      pad_q    <= PAD_ZERO;
      iaddr    <= '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= '0;
    end else begin
      state <= state_nx;
      if (iaddr_ld) iaddr <= nl_rc * W_A + nl_cc;
      case (state)
        START: begin
          mode_q   <= mode;
          pad_q    <= pad_mode;
          x        <= '0;
          y        <= '0;
          slot     <= '0;
          sort_cnt <= '0;
        end
        FETCH: begin
          slot     <= last_slot ? '0 : slot + 3'd1;
          sort_cnt <= '0;
          if (x == '0) begin
            if (slot < 3'd3) begin
              win[row_sel][1] <= pix;
              win[row_sel][0] <= (pad_q == PAD_REPL) ? pix : '0;
            end else begin
              win[row_sel][2] <= pix;
            end
          end else begin
            if (slot == '0) begin
              for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
              end
            end
            win[row_sel][2] <= pix;
          end
        end
        SORT: sort_cnt <= sort_cnt + 4'd1;
        WRITE: begin
          x <= x_nx;
          y <= y_nx;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        taps[r*3+c] = win[r][c];
  end

  mfe_sort9 #(.DW(DW)) u_sort (
    .clk     (clk),
    .reset_n (reset_n),
    .load    ((state == SORT) && (sort_cnt == 4'd0)),
    .en      ((state == SORT) && (sort_cnt != 4'd0)),
    .phase   (~sort_cnt[0]),
    .in      (taps),
    .out     (sorted)
  );

  assign busy    = (state == START) || (state == FETCH) || (state == SORT) || (state == WRITE);
  assign wen     = (state == WRITE);
  assign done    = (state == DONE);
  assign addr    = y * W_A + x;
  assign data_wr = wen ? sorted[rank_idx(mode_q)] : '0;

endmodule

// File: tb/tb_mfe_rank_filter.sv
// tb/tb_mfe_rank_filter.sv - randomized and directed checks of mfe_rank_filter against a reference model
module tb_mfe_rank_filter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ready_a = 1'b0, ready_b = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       pad_mode = 1'b0;
  logic       sel = 1'b0;

  logic [7:0] rom_a [16];
  logic [7:0] rom_b [16];

  logic       busy_a, wen_a, done_a, busy_b, wen_b, done_b;
  logic [3:0] iaddr_a, addr_a, iaddr_b, addr_b;
  logic [7:0] data_a, data_b, idata_a, idata_b;

  logic       s_busy, s_wen, s_done;
  logic [3:0] s_iaddr, s_addr;
  logic [7:0] s_data;

  int n_chk = 0;
  int n_fail = 0;
  int res [32];

  always #5 clk = ~clk;

  assign idata_a = rom_a[iaddr_a];
  assign idata_b = rom_b[iaddr_b];

  assign s_busy  = sel ? busy_b  : busy_a;
  assign s_wen   = sel ? wen_b   : wen_a;
  assign s_done  = sel ? done_b  : done_a;
  assign s_iaddr = sel ? iaddr_b : iaddr_a;
  assign s_addr  = sel ? addr_b  : addr_a;
  assign s_data  = sel ? data_b  : data_a;

  mfe_rank_filter #(.IMG_W(4), .IMG_H(4), .DW(8), .AW(4)) u_a (
    .clk(clk), .reset_n(rst_n), .ready(ready_a), .mode(mode), .pad_mode(pad_mode),
    .busy(busy_a), .iaddr(iaddr_a), .idata(idata_a), .addr(addr_a),
    .data_wr(data_a), .wen(wen_a), .done(done_a)
  );

  mfe_rank_filter #(.IMG_W(5), .IMG_H(3), .DW(8), .AW(4)) u_b (
    .clk(clk), .reset_n(rst_n), .ready(ready_b), .mode(mode), .pad_mode(pad_mode),
    .busy(busy_b), .iaddr(iaddr_b), .idata(idata_b), .addr(addr_b),
    .data_wr(data_b), .wen(wen_b), .done(done_b)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int pix(input int s, input int i);
    return s ? int'(rom_b[i]) : int'(rom_a[i]);
  endfunction

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  // Gather the 3x3 neighbourhood with border rules, sort it, pick the ranked element.
  function automatic int model(input int s, input int px, input int py, input int md, input int pd);
    int v [9];
    int w, h, n, xx, yy, t;
    w = s ? 5 : 4;
    h = s ? 3 : 4;
    n = 0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        xx = px + dx;
        yy = py + dy;
        if (xx >= 0 && xx < w && yy >= 0 && yy < h) v[n] = pix(s, yy*w + xx);
        else if (pd == 0)                             v[n] = 0;
        else v[n] = pix(s, clampi(yy, h-1)*w + clampi(xx, w-1));
        n++;
      end
    end
    for (int i = 1; i < 9; i++) begin
      t = v[i];
      for (int j = i - 1; j >= 0; j--) begin
        if (v[j] > t) begin
          v[j+1] = v[j];
          v[j] = t;
        end
      end
    end
    return (md == 1) ? v[0] : ((md == 2) ? v[8] : v[4]);
  endfunction

  task automatic run_frame(input int s, input int md, input int pd, input bit disturb, input int abort_at);
    int  w, h, cyc, nw, last_wen;
    bit  fin;
    w = s ? 5 : 4;
    h = s ? 3 : 4;
    sel = s[0];
    @(negedge clk);
    mode = 2'(md);
    pad_mode = pd[0];
    if (s != 0) ready_b = 1'b1; else ready_a = 1'b1;
    @(posedge clk);
    #1;
    ready_a = 1'b0;
    ready_b = 1'b0;
    cyc = 0; nw = 0; last_wen = 0; fin = 1'b0;
    while (!fin && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      chk("iaddr_range", (int'(s_iaddr) < w*h), 1);
      if (cyc == 1) chk("busy_start", s_busy, 1);
      if (abort_at > 0 && nw == abort_at && cyc == last_wen + 5) begin
        rst_n = 1'b0;
        #1;
        chk("abort_busy", s_busy, 0);
        chk("abort_wen", s_wen, 0);
        chk("abort_addr", s_addr, 0);
        chk("abort_iaddr", s_iaddr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        fin = 1'b1;
      end else if (s_wen) begin
        chk("wen_addr", s_addr, nw);
        chk("wen_data", s_data, model(s, nw % w, nw / w, md, pd));
        if (nw == 0) chk("first_wen_latency", cyc, 18);
        else         chk("wen_spacing", cyc - last_wen, ((nw % w) == 0) ? 17 : 14);
        res[nw] = int'(s_data);
        last_wen = cyc;
        nw++;
      end else if (s_done) begin
        chk("done_busy", s_busy, 0);
        chk("wen_count", nw, w*h);
        chk("done_after_last_wen", cyc - last_wen, 1);
        chk("frame_length", last_wen, h*(17 + (w-1)*14) + 1);
        fin = 1'b1;
      end
      if (disturb && !fin && (cyc % 7) == 0) begin
        mode = ~mode;
        pad_mode = ~pad_mode;
        if (s != 0) ready_b = ~ready_b; else ready_a = ~ready_a;
      end
    end
    ready_a = 1'b0;
    ready_b = 1'b0;
    if (!fin) chk("frame_timeout", 0, 1);
    @(negedge clk);
    chk("done_one_cycle", s_done, 0);
    chk("idle_busy", s_busy, 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom_a[i] = 8'(i * 10);
    for (int i = 0; i < 16; i++) rom_b[i] = 8'(i);
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_a, 0);
    chk("rst_wen", wen_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_iaddr", iaddr_a, 0);
    chk("rst_addr", addr_a, 0);
    chk("rst_data", data_a, 0);
    chk("rst_busy_b", busy_b, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_frame(0, 0, 0, 1'b0, -1);
    chk("t1_addr0", res[0], 0);
    chk("t1_addr5", res[5], 50);
    chk("t1_addr15", res[15], 0);

    run_frame(0, 2, 1, 1'b0, -1);
    chk("t2_max_addr0", res[0], 50);
    chk("t2_max_addr15", res[15], 150);
    run_frame(0, 1, 1, 1'b0, -1);
    chk("t2_min_addr5", res[5], 0);

    run_frame(0, 1, 0, 1'b0, 10);
    run_frame(0, 0, 1, 1'b0, -1);

    run_frame(0, 3, 0, 1'b1, -1);
    chk("t5_addr5", res[5], 50);

    for (int i = 0; i < 16; i++) rom_a[i] = 8'hFF;
    run_frame(0, 0, 0, 1'b0, -1);
    chk("t3_corner0", res[0], 0);
    chk("t3_corner3", res[3], 0);
    chk("t3_corner15", res[15], 0);
    chk("t3_edge1", res[1], 255);
    chk("t3_interior5", res[5], 255);

    for (int md = 0; md < 3; md++) begin
      for (int pd = 0; pd < 2; pd++) begin
        for (int i = 0; i < 16; i++) rom_b[i] = 8'($urandom_range(0, 255));
        run_frame(1, md, pd, 1'b0, -1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
